// File: rtl/fifo_gen_lram.sv
// fifo_gen_lram
// Single-clock synchronous FIFO of arbitrary depth built on LUT RAM.
// The RAM has a synchronous write and an asynchronous read.
// An occupancy counter is the only source of the full, empty and threshold flags.
// FWFT=1 presents the head word combinationally.
// FWFT=0 registers the head word on each accepted read.
//
// Ports:
//   clk        clock
//   rstn       synchronous active-low reset
//   i_flush    synchronous flush, discards contents (error flags kept)
//   i_clr_err  clears the sticky o_ovf / o_udf flags
//   i_wren     write request, i_wrdata write data
//   i_rden     read request (acknowledge of presented word in FWFT mode)
//   o_rddata   read data, o_rdvalid marks it valid
//   o_full     count == DEPTH,      o_afull  count >= AFULL_TH
//   o_empty    count == 0,          o_aempty count <= AEMPTY_TH
//   o_count    occupancy 0..DEPTH
//   o_ovf      sticky: a write was rejected
//   o_udf      sticky: a read was rejected
module fifo_gen_lram #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 6,
  parameter int FWFT      = 1,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_flush,
  input  logic              i_clr_err,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic              o_full,
  output logic              o_afull,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic              o_empty,
  output logic              o_aempty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_ovf,
  output logic              o_udf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] CNT_AEMPT = CNT_W'(AEMPTY_TH);

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_LAST) begin
      n = PTR_ZERO;
    end else begin
      n = p + PTR_ONE;
    end
    return n;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrptr;
  logic [PTR_W-1:0]  r_rdptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_udf;

  logic              w_empty;
  logic              w_full;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [PTR_W-1:0]  w_wrptr_nxt;
  logic [PTR_W-1:0]  w_rdptr_nxt;
  logic              w_ovf_set;
  logic              w_udf_set;

  assign w_empty  = (r_count == CNT_ZERO);
  assign w_full   = (r_count == CNT_DEPTH);
  // Accepted operations are suppressed while a flush is in progress.
  assign w_rd_acc = i_rden & ~w_empty & ~i_flush;
  // When full, an accepted read in the same cycle frees the slot.
  assign w_wr_acc = i_wren & (~w_full | (i_rden & ~w_empty)) & ~i_flush;
  assign w_ovf_set = i_wren & ~i_flush & ~(~w_full | (i_rden & ~w_empty));
  assign w_udf_set = i_rden & ~i_flush & w_empty;

  // Next-state for pointers and count.
  always_comb begin
    w_count_nxt = r_count;
    w_wrptr_nxt = r_wrptr;
    w_rdptr_nxt = r_rdptr;
    if (i_flush) begin
      w_count_nxt = CNT_ZERO;
      w_wrptr_nxt = PTR_ZERO;
      w_rdptr_nxt = PTR_ZERO;
    end else begin
      if (w_wr_acc) begin
        w_wrptr_nxt = ptr_inc(r_wrptr);
      end else begin
        w_wrptr_nxt = r_wrptr;
      end
      if (w_rd_acc) begin
        w_rdptr_nxt = ptr_inc(r_rdptr);
      end else begin
        w_rdptr_nxt = r_rdptr;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + CNT_ONE;
        2'b01:   w_count_nxt = r_count - CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= CNT_ZERO;
      r_wrptr <= PTR_ZERO;
      r_rdptr <= PTR_ZERO;
    end else begin
      r_count <= w_count_nxt;
      r_wrptr <= w_wrptr_nxt;
      r_rdptr <= w_rdptr_nxt;
    end
  end

  // LUT RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wrptr] <= i_wrdata;
    end
  end

  // Sticky error flags: a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (i_clr_err) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
      if (w_udf_set) begin
        r_udf <= 1'b1;
      end else if (i_clr_err) begin
        r_udf <= 1'b0;
      end else begin
        r_udf <= r_udf;
      end
    end
  end

  assign o_count  = r_count;
  assign o_empty  = w_empty;
  assign o_full   = w_full;
  assign o_afull  = (r_count >= CNT_AFULL);
  assign o_aempty = (r_count <= CNT_AEMPT);
  assign o_ovf    = r_ovf;
  assign o_udf    = r_udf;

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word presented straight from RAM; only rdptr sits in the path.
      assign o_rddata  = r_mem[r_rdptr];
      assign o_rdvalid = ~w_empty;
    end else begin : g_std
      logic [DATA_W-1:0] r_rddata;
      logic              r_rdvalid;

      // Registered read port: data holds, valid pulses for one cycle.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          r_rddata  <= {DATA_W{1'b0}};
          r_rdvalid <= 1'b0;
        end else if (w_rd_acc) begin
          r_rddata  <= r_mem[r_rdptr];
          r_rdvalid <= 1'b1;
        end else begin
          r_rddata  <= r_rddata;
          r_rdvalid <= 1'b0;
        end
      end

      assign o_rddata  = r_rddata;
      assign o_rdvalid = r_rdvalid;
    end
  endgenerate

endmodule
